// File: rtl/score_display.sv
// score_display: BCD game score and high score tracker with a 5x8 glyph column renderer
module score_display (
  input  logic        clk,
  input  logic        rst,
  input  logic        gameon,
  input  logic        score_tick,
  input  logic [5:0]  col_idx,
  output logic [7:0]  col_byte,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_bcd,
  output logic        new_hi,
  output logic        sat
);
  typedef enum logic [1:0] {IDLE, RUN, END} state_t;
  localparam logic [39:0] font [16] = '{
    40'h3E_45_49_51_3E, 40'h00_40_7F_42_00, 40'h46_49_51_61_42, 40'h31_4B_45_41_21,
    40'h10_7F_12_14_18, 40'h39_45_45_45_27, 40'h30_49_49_4A_3C, 40'h03_05_09_71_01,
    40'h36_49_49_49_36, 40'h1E_29_49_49_06, 40'h0, 40'h0, 40'h0, 40'h0, 40'h0, 40'h0
  };
  state_t state, next;
  logic        win;
  logic [15:0] inc;
  logic        cy;
  logic        in_s, in_h;
  logic [4:0]  c;
  logic [1:0]  n;
  logic [2:0]  k;
  logic [15:0] v;
  logic [3:0]  digit;
  logic [63:0] glyph;
  logic [7:0]  col_next;
  logic        ending;
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb
    next = state == IDLE ? (gameon ? RUN : IDLE) :
           state == RUN  ? (gameon ? RUN : END)  : IDLE;
  always_comb
    new_hi = state == END && win;
  always_comb begin
    inc = score_bcd;
    cy  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cy) begin
        cy = inc[4*i +: 4] == 4'd9;
        inc[4*i +: 4] = cy ? 4'd0 : inc[4*i +: 4] + 4'd1;
      end
    end
  end
  always_comb begin
    in_s     = col_idx < 6'd24;
    in_h     = col_idx >= 6'd28 && col_idx < 6'd52;
    c        = in_s ? col_idx[4:0] : 5'(col_idx - 6'd28);
    n        = 2'(c / 5'd6);
    k        = 3'(c % 5'd6);
    v        = in_s ? score_bcd : hi_bcd;
    digit    = v[{~n, 2'b00} +: 4];
    glyph    = {24'h0, font[digit]};
    col_next = (in_s || in_h) ? glyph[{k, 3'b000} +: 8] : 8'h00;
  end
  assign ending = state == RUN && !gameon;
  always_ff @(posedge clk) begin
    if (rst) begin
      score_bcd <= '0;
      hi_bcd    <= '0;
      sat       <= 1'b0;
      win       <= 1'b0;
      col_byte  <= '0;
    end else begin
      col_byte <= col_next;
      win      <= ending && score_bcd > hi_bcd;
      if (ending && score_bcd > hi_bcd) hi_bcd <= score_bcd;
      if (state == IDLE && gameon) begin
        score_bcd <= '0;
        sat       <= 1'b0;
      end else if (state == RUN && gameon && score_tick) begin
        score_bcd <= score_bcd == 16'h9999 ? score_bcd : inc;
        sat       <= sat || score_bcd == 16'h9999;
      end
    end
  end
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: randomized and directed checks of score_display against an integer-arithmetic model
module tb_score_display;
  logic        clk = 0, rst = 1, gameon = 0, score_tick = 0;
  logic [5:0]  col_idx = 0;
  logic [7:0]  col_byte;
  logic [15:0] score_bcd, hi_bcd;
  logic        new_hi, sat;
  int checks = 0, failures = 0;
  int m_phase = 0, m_score = 0, m_hi = 0, m_sat = 0, m_new = 0, m_col = 0;
  logic [7:0] fnt [10][5] = '{
    '{8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E}, '{8'h00, 8'h42, 8'h7F, 8'h40, 8'h00},
    '{8'h42, 8'h61, 8'h51, 8'h49, 8'h46}, '{8'h21, 8'h41, 8'h45, 8'h4B, 8'h31},
    '{8'h18, 8'h14, 8'h12, 8'h7F, 8'h10}, '{8'h27, 8'h45, 8'h45, 8'h45, 8'h39},
    '{8'h3C, 8'h4A, 8'h49, 8'h49, 8'h30}, '{8'h01, 8'h71, 8'h09, 8'h05, 8'h03},
    '{8'h36, 8'h49, 8'h49, 8'h49, 8'h36}, '{8'h06, 8'h49, 8'h49, 8'h29, 8'h1E}
  };
  score_display dut (
    .clk(clk), .rst(rst), .gameon(gameon), .score_tick(score_tick), .col_idx(col_idx),
    .col_byte(col_byte), .score_bcd(score_bcd), .hi_bcd(hi_bcd), .new_hi(new_hi), .sat(sat)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] to_bcd(input int x);
    return 16'((x / 1000) * 4096 + (x / 100 % 10) * 256 + (x / 10 % 10) * 16 + x % 10);
  endfunction
  function automatic int glyph_col(input int c, input int s, input int h);
    int val, pos, d, k, p;
    if (c < 24) begin val = s; pos = c; end
    else if (c >= 28 && c < 52) begin val = h; pos = c - 28; end
    else return 0;
    k = pos % 6;
    if (k == 5) return 0;
    p = (pos / 6 == 0) ? 1000 : (pos / 6 == 1) ? 100 : (pos / 6 == 2) ? 10 : 1;
    d = val / p % 10;
    return int'(fnt[d][k]);
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic g, input logic t, input int c);
    @(negedge clk);
    rst = r; gameon = g; score_tick = t; col_idx = 6'(c);
    @(posedge clk);
    if (r) begin
      m_phase = 0; m_score = 0; m_hi = 0; m_sat = 0; m_new = 0; m_col = 0;
    end else begin
      m_col = glyph_col(c, m_score, m_hi);
      m_new = 0;
      if (m_phase == 0) begin
        if (g) begin m_phase = 1; m_score = 0; m_sat = 0; end
      end else if (m_phase == 1) begin
        if (!g) begin
          m_phase = 2;
          if (m_score > m_hi) begin m_hi = m_score; m_new = 1; end
        end else if (t) begin
          if (m_score == 9999) m_sat = 1; else m_score++;
        end
      end else m_phase = 0;
    end
    #1;
    chk("score_bcd", score_bcd, to_bcd(m_score));
    chk("hi_bcd", hi_bcd, to_bcd(m_hi));
    chk("sat", 16'(sat), 16'(m_sat));
    chk("new_hi", 16'(new_hi), 16'(m_new));
    chk("col_byte", 16'(col_byte), 16'(m_col));
  endtask
  task automatic rstep(input logic r, input logic g, input logic t);
    step(r, g, t, int'($urandom_range(0, 63)));
  endtask
  task automatic game(input int ticks);
    rstep(0, 1, 0);
    repeat (ticks) rstep(0, 1, 1);
    rstep(0, 0, 0);
    rstep(0, 0, 0);
  endtask
  initial begin
    int g;
    rstep(1, 0, 0);
    rstep(1, 1, 1);
    game(1234);
    rstep(0, 0, 1);
    rstep(0, 1, 1);
    repeat (99) rstep(0, 1, 1);
    rstep(0, 1, 1);
    repeat (9999 - 100 + 3) rstep(0, 1, 1);
    rstep(0, 0, 0);
    rstep(0, 0, 0);
    rstep(0, 1, 0);
    rstep(0, 0, 0);
    rstep(0, 0, 0);
    rstep(1, 0, 0);
    game(500);
    game(500);
    game(501);
    rstep(0, 1, 0);
    repeat (729) rstep(0, 1, 0 + 1);
    step(0, 1, 0, 12);
    step(0, 1, 0, 17);
    step(0, 1, 0, 25);
    step(0, 1, 0, 55);
    step(0, 1, 0, 30);
    rstep(0, 0, 0);
    rstep(0, 0, 0);
    rstep(1, 0, 0);
    rstep(0, 1, 0);
    repeat (42) rstep(0, 1, 1);
    rstep(1, 1, 1);
    rstep(0, 0, 0);
    rstep(0, 0, 0);
    game(7);
    rstep(0, 1, 0);
    repeat (3) rstep(0, 1, 1);
    rstep(0, 0, 0);
    rstep(1, 0, 0);
    g = 0;
    repeat (4000) begin
      if ($urandom_range(0, 19) == 0) g = 1 - g;
      rstep($urandom_range(0, 199) == 0, 1'(g), 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 The block SHALL have exactly one clock, and reset SHALL be synchronous and active-high.
REQ-002 clk  in  1  system clock (27 MHz board clock); all state changes on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 gameon  in  1  game-running level from the screen driver.
REQ-005 score_tick  in  1  single-cycle score pulse from the pattern generator.
REQ-006 col_idx  in  6  score-field column requested by the pattern generator, 0..63.
REQ-007 col_byte  out  8  registered glyph column; bit0 = top pixel row.
REQ-008 score_bcd  out  16  current score, 4 BCD digits; [15:12] = thousands.
REQ-009 hi_bcd  out  16  high score, 4 BCD digits, same layout.
REQ-010 new_hi  out  1  one-cycle pulse: the game just ended with a new high score.
REQ-011 sat  out  1  current score is held at 9999.

Function
REQ-012 FSM states SHALL be IDLE, RUN and END.
REQ-013 IDLE -> RUN SHALL occur when gameon=1; on that edge score SHALL be set to 0000 and sat SHALL be cleared.
REQ-014 RUN -> END SHALL occur when gameon=0; END -> IDLE SHALL be unconditional, with END lasting exactly 1 cycle.
REQ-015 In RUN with gameon=1 and score_tick=1, score SHALL increment by 1 in decimal, with a ripple carry across digits.
REQ-016 At 9999 a further tick SHALL leave the score unchanged and set sat=1; sat SHALL hold until the next IDLE -> RUN transition.
REQ-017 score_tick SHALL be ignored in IDLE, in END, and on the IDLE -> RUN edge, where clear has priority and the tick is dropped.
REQ-018 On the RUN -> END edge: if score > hi (unsigned compare of the 4-digit value), hi SHALL load score and new_hi SHALL be 1 during END; otherwise new_hi SHALL be 0.
REQ-019 A score equal to hi SHALL NOT count as a new high.
REQ-020 new_hi SHALL be 1 only in END.
REQ-021 Score SHALL remain visible in IDLE until the next game starts.
REQ-022 Column map for col_idx:
- 0..23: score digit n = col_idx/6 (n=0 thousands), sub-column k = col_idx mod 6.
- 24..27: blank.
- 28..51: hi digit, mapped the same way using col_idx-28.
- 52..63: blank (0x00).
REQ-023 Within a digit, k=0..4 SHALL output font[digit][k] and k=5 SHALL output 0x00.
REQ-024 The font table SHALL be as follows (hex, k=0..4):
- 0: 3E 51 49 45 3E
- 1: 00 42 7F 40 00
- 2: 42 61 51 49 46
- 3: 21 41 45 4B 31
- 4: 18 14 12 7F 10
- 5: 27 45 45 45 39
- 6: 3C 4A 49 49 30
- 7: 01 71 09 05 03
- 8: 36 49 49 49 36
- 9: 06 49 49 29 1E
REQ-025 col_byte latency SHALL be 1 cycle: the value after edge N SHALL reflect col_idx and score/hi as sampled at edge N.
REQ-026 score_bcd, hi_bcd and sat SHALL be direct register outputs.
REQ-027 Every BCD digit SHALL remain within 0..9 at all times.

Reset
REQ-028 With rst=1 at an edge: state SHALL go to IDLE; score_bcd, hi_bcd and col_byte SHALL be 0x0000 / 0x0000 / 0x00; new_hi and sat SHALL be 0.
REQ-029 rst SHALL override all other inputs, including mid-RUN and during END.
REQ-030 The first post-reset cycle with gameon=1 SHALL start a game normally.

Verification
REQ-031 Reset, gameon 0->1, 1234 ticks, gameon->0 -> score_bcd=0x1234, hi_bcd=0x1234, new_hi=1 for exactly one cycle.
REQ-032 Score ticked to 0x0099, then one tick -> 0x0100; ticks continued to 9999 plus 3 extra -> 0x9999, sat=1; next game start -> score 0x0000, sat=0.
REQ-033 hi=0x0500, new game ending at 0x0500 -> new_hi stays 0, hi unchanged; game ending at 0x0501 -> hi=0x0501, new_hi pulse.
REQ-034 Tick on the same edge as gameon 0->1 -> score 0x0000; tick while gameon=0 -> no change.
REQ-035 score=0x0729: col_idx=12 -> col_byte=0x42 one cycle later; col_idx=17 -> 0x00; col_idx=25 -> 0x00; col_idx=55 -> 0x00.
REQ-036 rst pulse mid-RUN at score 0x0042 -> all outputs at reset values the next cycle; new_hi never asserts.
